vslc_btn_debounce: RTL and testbench

VSLC_BTN_DEBOUNCE -- requirements
Module: vslc_btn_debounce

---
 rtl/vslc_btn_debounce.sv | 88 ++++++++
 tb/tb_vslc_btn_debounce.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vslc_btn_debounce.sv
// Multi-channel push-button debouncer: two-flop synchronizer, polarity
// normalisation, per-channel stability counter and registered edge pulses.
module vslc_btn_debounce #(
  parameter int unsigned          N_BTN         = 4,
  parameter int unsigned          STABLE_CYCLES = 12000,
  parameter logic [N_BTN-1:0]     INV_MASK      = 4'b0001
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic             btn_any
);

  localparam int unsigned    CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] samp_s;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] rise_q, rise_d;
  logic [N_BTN-1:0] fall_q, fall_d;
  logic             any_q, any_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];

  // Synchronizers idle at the inactive raw level so the normalized sample is 0 in reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= INV_MASK;
      sync2_q <= INV_MASK;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign samp_s = sync2_q ^ INV_MASK;

  // Per-channel stability window; any agreement with the current level restarts it.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < int'(N_BTN); i++) begin
      cnt_d[i] = cnt_q[i];
      if (samp_s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = samp_s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1'b1);
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
    any_d  = |rise_d;
  end

  // Debounce state and registered pulse outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;
  assign btn_any   = any_q;

endmodule

// File: tb/tb_vslc_btn_debounce.sv
// Directed bench for vslc_btn_debounce with STABLE_CYCLES=4: latency, glitch
// rejection, simultaneous channels and reset behaviour.
module tb_vslc_btn_debounce;

  logic       CLK;
  logic       RST;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_rise;
  logic [3:0] btn_fall;
  logic       btn_any;

  int n_cmp;
  int n_bad;
  int any_pulses;

  vslc_btn_debounce #(
    .N_BTN         (4),
    .STABLE_CYCLES (4),
    .INV_MASK      (4'b0001)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_any   (btn_any)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e, input logic [3:0] lvl,
                            input logic [3:0] rise, input logic [3:0] fall, input logic any);
    string t;
    t = $sformatf("%s e%0d", tag, e);
    check_eq({t, " level"}, {28'd0, btn_level}, {28'd0, lvl});
    check_eq({t, " rise"},  {28'd0, btn_rise},  {28'd0, rise});
    check_eq({t, " fall"},  {28'd0, btn_fall},  {28'd0, fall});
    check_eq({t, " any"},   {31'd0, btn_any},   {31'd0, any});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    RST     = 1'b1;
    btn_raw = 4'b0001;
    tick();
    tick();
    check_outs("reset", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Idle release: no pulses at all
    RST = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      check_outs("idle", e, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end

    // Active-high press on bit 1: level at edge 5, one-cycle rise
    btn_raw[1] = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      check_outs("press1", e, (e >= 5) ? 4'b0010 : 4'b0000,
                 (e == 5) ? 4'b0010 : 4'b0000, 4'b0000, e == 5);
    end

    // Active-low press then release on bit 0
    btn_raw[0] = 1'b0;
    for (int e = 0; e < 7; e++) begin
      tick();
      check_outs("press0", e, (e >= 5) ? 4'b0011 : 4'b0010,
                 (e == 5) ? 4'b0001 : 4'b0000, 4'b0000, e == 5);
    end
    btn_raw[0] = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      check_outs("rel0", e, (e >= 5) ? 4'b0010 : 4'b0011,
                 4'b0000, (e == 5) ? 4'b0001 : 4'b0000, 1'b0);
    end

    // Glitch on bit 2: high 3, low 1, high -> level only at edge 9
    btn_raw[2] = 1'b1;
    for (int e = 0; e < 11; e++) begin
      tick();
      check_outs("glitch2", e, (e >= 9) ? 4'b0110 : 4'b0010,
                 (e == 9) ? 4'b0100 : 4'b0000, 4'b0000, e == 9);
      if (e == 2) btn_raw[2] = 1'b0;
      if (e == 3) btn_raw[2] = 1'b1;
    end

    // Release bit 1 so it can rise together with bit 3
    btn_raw[1] = 1'b0;
    for (int e = 0; e < 7; e++) begin
      tick();
      check_outs("rel1", e, (e >= 5) ? 4'b0100 : 4'b0110,
                 4'b0000, (e == 5) ? 4'b0010 : 4'b0000, 1'b0);
    end

    // Simultaneous press on bits 1 and 3
    any_pulses = 0;
    btn_raw[1] = 1'b1;
    btn_raw[3] = 1'b1;
    for (int e = 0; e < 9; e++) begin
      tick();
      if (btn_any) any_pulses++;
      check_outs("dual", e, (e >= 5) ? 4'b1110 : 4'b0100,
                 (e == 5) ? 4'b1010 : 4'b0000, 4'b0000, e == 5);
    end
    check_eq("dual any_count", any_pulses, 32'd1);

    // Reset mid-count of a bit-0 press, buttons held through release
    btn_raw[0] = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      check_outs("precnt", e, 4'b1110, 4'b0000, 4'b0000, 1'b0);
    end
    RST = 1'b1;
    #1;
    check_outs("rst_async", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int e = 1; e < 3; e++) begin
      tick();
      check_outs("rst_hold", e, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    RST = 1'b0;
    for (int e = 0; e < 7; e++) begin
      tick();
      check_outs("post_rst", e, (e >= 5) ? 4'b1111 : 4'b0000,
                 (e == 5) ? 4'b1111 : 4'b0000, 4'b0000, e == 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
